// File: rtl/phase_baseline_sampler.sv
// -----------------------------------------------------------------------------
// phase_baseline_sampler
//
// Decimates the per-CE smoothed phase/period value from the IIR phase-shift
// filter down to one sample every SAMPLE_DIV enabled cycles. It subtracts a
// calibration baseline from each sample and clamps the result at zero. The
// corrected samples go into a small first-word-fall-through FIFO for the
// readout side.
//
// An on-request calibration pass averages 2^CAL_SHIFT decimated samples and
// stores the average as the new baseline.
//
// Ports
//   CLK             single clock, all logic on the rising edge
//   RESET           synchronous, active-high
//   CE              input-sample enable (filter update rate)
//   PERIOD_IN       filtered phase value, unsigned, W bits
//   CALIBRATE       level request for a baseline measurement. It is only
//                   looked at while running, and ignored during calibration.
//   OUT_VALID       FIFO holds at least one sample
//   OUT_READY       consumer accepts the head sample
//   OUT_DATA        head sample (baseline corrected); 0 while OUT_VALID=0
//   CAL_OFFSET      current baseline
//   CAL_BUSY        calibration in progress
//   OVERFLOW_COUNT  samples dropped because the FIFO was full (saturating)
//
// Output handshake: a transfer happens in every cycle where OUT_VALID and
// OUT_READY are both high. OUT_VALID does not wait for OUT_READY. OUT_DATA
// stays stable while OUT_VALID=1 and OUT_READY=0. A transfer does not depend
// on CE.
// -----------------------------------------------------------------------------
module phase_baseline_sampler #(
  parameter int PERIOD_INT_PART  = 10,
  parameter int PERIOD_FRAC_PART = 20,
  parameter int SAMPLE_DIV       = 256,
  parameter int CAL_SHIFT        = 4,
  parameter int FIFO_DEPTH_BITS  = 2,
  parameter int OVF_BITS         = 16
) (
  input  logic                                        CLK,
  input  logic                                        RESET,
  input  logic                                        CE,
  input  logic [PERIOD_INT_PART+PERIOD_FRAC_PART-1:0] PERIOD_IN,
  input  logic                                        CALIBRATE,
  output logic                                        OUT_VALID,
  input  logic                                        OUT_READY,
  output logic [PERIOD_INT_PART+PERIOD_FRAC_PART-1:0] OUT_DATA,
  output logic [PERIOD_INT_PART+PERIOD_FRAC_PART-1:0] CAL_OFFSET,
  output logic                                        CAL_BUSY,
  output logic [OVF_BITS-1:0]                         OVERFLOW_COUNT
);

  localparam int W      = PERIOD_INT_PART + PERIOD_FRAC_PART;
  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int CNT_W  = (CAL_SHIFT > 0) ? CAL_SHIFT : 1;
  localparam int ACC_W  = W + CAL_SHIFT;
  localparam int DEPTH  = 1 << FIFO_DEPTH_BITS;
  localparam int PTR_W  = FIFO_DEPTH_BITS;

  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0]    CAL_LAST = CNT_W'((1 << CAL_SHIFT) - 1);
  localparam logic [PTR_W:0]      FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [OVF_BITS-1:0] OVF_MAX  = '1;

  // ---------------------------------------------------------------------------
  // Decimation divider
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             strobe;
  logic             cal_start;

  assign strobe = CE && (div_cnt == DIV_LAST);

  // When calibration starts, the divider is realigned so that the averaging
  // window always covers whole decimation periods from the request onward.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_cnt <= '0;
    end else if (cal_start) begin
      div_cnt <= '0;
    end else if (CE) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Run / calibrate FSM (state register, next-state, outputs)
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_CAL = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cal_cnt;
  logic             cal_last_hit;
  logic             run_sample;
  logic             cal_accum;
  logic             cal_done;
  logic             busy;

  assign cal_last_hit = (cal_cnt == CAL_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: if (CALIBRATE) state_d = ST_CAL;
      ST_CAL: if (strobe && cal_last_hit) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // In the cycle where calibration starts, the FSM is still in RUN. A strobe
  // in that cycle therefore produces a normal sample that uses the old
  // baseline.
  always_comb begin
    run_sample = 1'b0;
    cal_start  = 1'b0;
    cal_accum  = 1'b0;
    cal_done   = 1'b0;
    busy       = 1'b0;
    case (state_q)
      ST_RUN: begin
        run_sample = strobe;
        cal_start  = CALIBRATE;
      end
      ST_CAL: begin
        cal_accum = strobe;
        cal_done  = strobe && cal_last_hit;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  assign CAL_BUSY = busy;

  // ---------------------------------------------------------------------------
  // Calibration accumulator and baseline
  // ---------------------------------------------------------------------------
  // The accumulator is CAL_SHIFT bits wider than a sample. A sum of
  // 2^CAL_SHIFT samples therefore cannot overflow it.
  logic [ACC_W-1:0] cal_acc;
  logic [ACC_W-1:0] acc_sum;
  logic [W-1:0]     cal_offset;

  assign acc_sum = cal_acc + ACC_W'(PERIOD_IN);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cal_acc    <= '0;
      cal_cnt    <= '0;
      cal_offset <= '0;
    end else if (cal_start) begin
      cal_acc <= '0;
      cal_cnt <= '0;
    end else if (cal_accum) begin
      cal_acc <= acc_sum;
      cal_cnt <= cal_cnt + CNT_W'(1);
      // The last sample is folded in directly. The average is truncated.
      if (cal_done) begin
        cal_offset <= W'(acc_sum >> CAL_SHIFT);
      end
    end
  end

  assign CAL_OFFSET = cal_offset;

  // ---------------------------------------------------------------------------
  // Baseline subtraction and sample register
  // ---------------------------------------------------------------------------
  // The subtraction is done one bit wider than a sample. The extra top bit
  // is then the sign, so a negative difference clamps to 0.
  logic [W:0]   diff;
  logic [W-1:0] corrected;
  logic [W-1:0] sample_data;
  logic         sample_vld;

  assign diff      = {1'b0, PERIOD_IN} - {1'b0, cal_offset};
  assign corrected = diff[W] ? '0 : diff[W-1:0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sample_vld  <= 1'b0;
      sample_data <= '0;
    end else begin
      sample_vld <= run_sample;
      if (run_sample) begin
        sample_data <= corrected;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FWFT output FIFO
  // ---------------------------------------------------------------------------
  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             push_ok;
  logic             drop;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign pop        = !fifo_empty && OUT_READY;
  // A push into a full FIFO is still accepted when the head leaves in the
  // same cycle. The write then lands in the slot being vacated, which
  // becomes the new tail.
  assign push_ok    = sample_vld && (!fifo_full || pop);
  assign drop       = sample_vld && fifo_full && !pop;

  // Storage is not reset. Entries are only visible through count, and
  // OUT_DATA is masked while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= sample_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign OUT_VALID = !fifo_empty;
  assign OUT_DATA  = fifo_empty ? '0 : mem[rd_ptr];

  // ---------------------------------------------------------------------------
  // Dropped-sample counter (saturating)
  // ---------------------------------------------------------------------------
  logic [OVF_BITS-1:0] ovf_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ovf_cnt <= '0;
    end else if (drop && (ovf_cnt != OVF_MAX)) begin
      ovf_cnt <= ovf_cnt + OVF_BITS'(1);
    end
  end

  assign OVERFLOW_COUNT = ovf_cnt;

endmodule

// File: doc/phase_baseline_sampler.md
# phase_baseline_sampler

Downstream consumer of the smoothed phase/period value produced by the IIR phase-shift filter. It decimates the per-CE filtered value to a lower sample rate and subtracts a calibration baseline (hand-far offset) with clamp-at-zero. An on-request calibration FSM measures that baseline by averaging samples. Results are buffered in a small FWFT FIFO with a valid/ready handshake toward the CPU/readout side.

## Interface
- PERIOD_INT_PART, 10, integer bits of input value
- PERIOD_FRAC_PART, 20, fractional bits; W = PERIOD_INT_PART+PERIOD_FRAC_PART
- SAMPLE_DIV, 256, CE cycles per output sample (≥2)
- CAL_SHIFT, 4, calibration averages 2^CAL_SHIFT samples
- FIFO_DEPTH_BITS, 2, FIFO holds 2^FIFO_DEPTH_BITS entries
- OVF_BITS, 16, overflow counter width

- CLK  in  1  single clock; one clock, all logic on posedge
- RESET  in  1  synchronous, active-high
- CE  in  1  input-sample enable (filter update rate)
- PERIOD_IN  in  W  filtered phase value, unsigned
- CALIBRATE  in  1  request baseline measurement (level sampled per cycle)
- OUT_VALID  out  1  FIFO non-empty
- OUT_READY  in  1  consumer accepts head
- OUT_DATA  out  W  baseline-corrected sample
- CAL_OFFSET  out  W  current baseline
- CAL_BUSY  out  1  calibration in progress
- OVERFLOW_COUNT  out  OVF_BITS  dropped-sample count, saturating

## Operation
- Divider: counter 0..SAMPLE_DIV-1, advances only when CE=1; strobe in cycle where CE=1 and counter=SAMPLE_DIV-1 (counter wraps to 0). CE=0: counter holds, no strobe.
- States: RUN, CAL. Reset -> RUN.
- RUN: on strobe, capture clamp(PERIOD_IN − CAL_OFFSET) into sample register (difference computed W+1 bits signed; negative -> 0, else low W bits) with sample_vld=1; next cycle sample is pushed to FIFO.
- RUN -> CAL: CALIBRATE=1 in a RUN cycle. Divider cleared to 0, accumulator (W+CAL_SHIFT bits) and cal sample count cleared. A strobe coinciding with that cycle is still processed as a RUN sample (old offset). CALIBRATE ignored while in CAL.
- CAL: strobes are not pushed; PERIOD_IN added to accumulator. On the 2^CAL_SHIFT-th strobe: CAL_OFFSET <= (acc + PERIOD_IN) >> CAL_SHIFT (truncate), state -> RUN.
- FIFO: FWFT. OUT_VALID = non-empty; OUT_DATA = head when valid, forced 0 when OUT_VALID=0. Pop = OUT_VALID & OUT_READY, independent of CE.
- Push when full: accepted if a pop occurs in the same cycle; otherwise sample dropped and OVERFLOW_COUNT increments, saturating at all-ones.
- Push and pop in the same cycle while not empty: occupancy unchanged, order preserved.

## Timing
- Reset values: OUT_VALID=0, OUT_DATA=0, CAL_OFFSET=0, CAL_BUSY=0, OVERFLOW_COUNT=0; divider 0, FIFO empty, sample_vld=0, state RUN.
- Strobe in cycle T -> sample register loaded at end of T -> FIFO write at end of T+1 -> OUT_VALID=1 in T+2 (latency 2) if FIFO was empty.
- First strobe after reset with CE held high: cycle SAMPLE_DIV-1 (cycle 0 = first after reset deassert).
- CALIBRATE in cycle C -> CAL_BUSY=1 from C+1. Final cal strobe in cycle S -> CAL_OFFSET updated and CAL_BUSY=0 in S+1; strobes from S+1 use new offset.
- Sample already in sample register when CAL starts is still pushed.
- RESET mid-calibration or mid-transfer: everything returns to reset values next cycle; FIFO contents discarded, no partial offset update.

## Test plan
(SAMPLE_DIV=4, CAL_SHIFT=2, FIFO_DEPTH_BITS=2 unless noted)
- Reset, CE=1, OUT_READY=1, PERIOD_IN=0x12345678 -> first OUT_VALID in cycle 5, one-cycle pulse every 4 cycles, OUT_DATA=0x12345678, CAL_OFFSET=0.
- Pulse CALIBRATE; PERIOD_IN=100,104,108,112 at the four cal strobes -> no FIFO pushes, CAL_BUSY high for exactly the window, CAL_OFFSET=106; then PERIOD_IN=200 -> OUT_DATA=94; PERIOD_IN=50 -> OUT_DATA=0.
- OUT_READY=0, six strobes with values 1..6 -> OVERFLOW_COUNT=2; then OUT_READY=1 pops 1,2,3,4 in order, OUT_DATA=0 after empty.
- FIFO full, OUT_READY=1 only in the push cycle -> no drop, occupancy stays 4, head advances.
- CE high every other cycle -> strobe every 8 clocks; pops with CE=0 still complete; OVF_BITS=2 with 5 drops -> OVERFLOW_COUNT saturates at 3.
- RESET asserted after 2 of 4 cal strobes -> next cycle CAL_BUSY=0, CAL_OFFSET=0, OUT_VALID=0; subsequent samples uncorrected.
